// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask,
// lowest-index priority and a three-state request/acknowledge handshake with the core.
//
// state  | meaning
// IDLE   | no request outstanding; picks lowest pending+enabled source
// ASSERT | Interrupt high, waiting for the core's IntReset
// ACK    | acknowledge seen, waiting for IntReset to drop
module interrupt_controller #(
  parameter int          N_SRC     = 4,
  parameter int          ID_W      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Sel,
  input  logic [N_SRC-1:0] irq_src,
  output logic             Interrupt,
  input  logic             IntReset,
  output logic [ID_W-1:0]  ActiveId
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] s1, s2, prev;
  logic [N_SRC-1:0] rise, pend, en, req, w1c, ack_clr;
  logic [1:0]       off;
  logic             wr_pend, wr_en, busy;
  logic [ID_W-1:0]  low_id;
  logic             unused_bits;

  assign Sel     = (Addr[31:4] == BASE_ADDR[31:4]);
  assign off     = Addr[3:2];
  assign wr_pend = MemWrite & Sel & (off == 2'd0);
  assign wr_en   = MemWrite & Sel & (off == 2'd1);
  assign rise    = s2 & ~prev;
  assign req     = pend & en;
  assign busy    = (state != IDLE);
  assign w1c     = wr_pend ? WriteData[N_SRC-1:0] : '0;

  // Byte lanes and data bits beyond the implemented sources carry no meaning here.
  assign unused_bits = ^{Addr[1:0], WriteData[31:N_SRC]};

  // Acknowledge clears only the source being serviced.
  always_comb begin
    ack_clr = '0;
    if (state == ASSERT && IntReset) ack_clr[ActiveId] = 1'b1;
  end

  // Priority pick: scanning downward leaves the lowest set index.
  always_comb begin
    low_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) low_id = ID_W'(i);
    end
  end

  // Register read mux; anything outside the block reads as zero.
  always_comb begin
    ReadData = '0;
    if (Sel) begin
      case (off)
        2'd0:    ReadData[N_SRC-1:0] = pend;
        2'd1:    ReadData[N_SRC-1:0] = en;
        2'd2:    ReadData[ID_W:0]    = {busy, ActiveId};
        default: ReadData = '0;
      endcase
    end
  end

  // Two-flop synchronizer plus previous-sample flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= irq_src;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Pending and enable registers; a same-cycle rise beats any clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      en   <= '0;
    end else begin
      pend <= (pend & ~(w1c | ack_clr)) | rise;
      if (wr_en) en <= WriteData[N_SRC-1:0];
    end
  end

  // Request/acknowledge FSM with registered Interrupt and ActiveId.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Interrupt <= 1'b0;
      ActiveId  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ActiveId  <= low_id;
            Interrupt <= 1'b1;
            state     <= ASSERT;
          end
        end
        ASSERT: begin
          if (IntReset) begin
            Interrupt <= 1'b0;
            state     <= ACK;
          end
        end
        ACK: begin
          if (!IntReset) state <= IDLE;
        end
        default: begin
          Interrupt <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_interrupt_controller;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Sel;
  logic [3:0]  irq_src = 4'h0;
  logic        Interrupt;
  logic        IntReset = 1'b0;
  logic [1:0]  ActiveId;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.N_SRC(4), .ID_W(2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .Sel(Sel),
    .irq_src(irq_src), .Interrupt(Interrupt), .IntReset(IntReset),
    .ActiveId(ActiveId)
  );

  always #5 clk = ~clk;

  // Behavioural model. h1/h2/h3 are irq_src as sampled one, two and three
  // edges ago: a level first seen at edge k becomes pending at edge k+2.
  logic [3:0] m_pend, m_en, h1, h2, h3;
  logic [1:0] m_id;
  int         m_phase;  // 0 waiting, 1 requesting, 2 acknowledged
  logic       m_irq;

  always @(posedge clk or negedge reset) begin
    logic [3:0] rise, clr, en_n, pe;
    logic       bsel;
    if (!reset) begin
      m_pend = 0; m_en = 0; m_id = 0; m_phase = 0; m_irq = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      rise = h2 & ~h3;
      bsel = (Addr[31:4] == BASE[31:4]);
      clr  = 0;
      if (MemWrite && bsel && Addr[3:2] == 2'd0) clr = WriteData[3:0];
      if (m_phase == 1 && IntReset) clr[m_id] = 1'b1;
      en_n = (MemWrite && bsel && Addr[3:2] == 2'd1) ? WriteData[3:0] : m_en;
      pe = m_pend & m_en;
      if (m_phase == 0 && pe != 0) begin
        m_id = 2'($clog2(int'(pe & (~pe + 4'd1))));
        m_phase = 1; m_irq = 1;
      end else if (m_phase == 1 && IntReset) begin
        m_phase = 2; m_irq = 0;
      end else if (m_phase == 2 && !IntReset) begin
        m_phase = 0;
      end
      m_pend = (m_pend & ~clr) | rise;
      m_en = en_n;
      h3 = h2; h2 = h1; h1 = irq_src;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0: return {28'h0, m_pend};
      2'd1: return {28'h0, m_en};
      2'd2: return {29'h0, (m_phase != 0), m_id};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic quiesce();
    irq_src = 0; IntReset = 0; MemWrite = 0;
    repeat (4) tick();
    bus_write(BASE + 4, 0);
    bus_write(BASE, 32'hF);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      irq_src = 4'($urandom); MemWrite = 1'($urandom); IntReset = 1'($urandom);
      Addr = BASE + 32'($urandom_range(0, 3) * 4); WriteData = $urandom;
      tick();
    end
    checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", Interrupt); end
    checks++; if (ActiveId !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", ActiveId); end
    for (int o = 0; o < 3; o++) begin
      Addr = BASE + 32'(o * 4); #1;
      checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_rd off%0d got %h want 0", o, ReadData); end
    end
    MemWrite = 0; IntReset = 0; irq_src = 0;
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_single_and_read();
    quiesce();
    bus_write(BASE + 4, 32'hF);
    irq_src = 4'b0100;
    tick(); tick();  // edges k, k+1
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL t2_pend_early got %h want 0", ReadData); end
    tick();          // k+2
    checks++; if (ReadData !== 32'h4) begin errors++; $display("FAIL t2_pend got %h want 4", ReadData); end
    checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL t2_irq_early got %b want 0", Interrupt); end
    tick();          // k+3
    checks++; if (Interrupt !== 1'b1) begin errors++; $display("FAIL t2_irq got %b want 1", Interrupt); end
    checks++; if (ActiveId !== 2'd2) begin errors++; $display("FAIL t2_id got %0d want 2", ActiveId); end
    Addr = BASE + 8; #1;
    checks++; if (ReadData !== 32'h6 || Sel !== 1'b1) begin errors++; $display("FAIL t7_active got rd=%h sel=%b want 6/1", ReadData, Sel); end
    Addr = BASE + 16; #1;
    checks++; if (ReadData !== 32'h0 || Sel !== 1'b0) begin errors++; $display("FAIL t7_outside got rd=%h sel=%b want 0/0", ReadData, Sel); end
    IntReset = 1; Addr = BASE;
    tick();
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL t2_ack_pend got %h want 0", ReadData); end
    checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL t2_ack_irq got %b want 0", Interrupt); end
    IntReset = 0; irq_src = 0;
    tick(); tick();
  endtask

  task automatic test_priority();
    quiesce();
    bus_write(BASE + 4, 32'hF);
    irq_src = 4'b1010;
    repeat (4) tick();
    checks++; if (Interrupt !== 1'b1 || ActiveId !== 2'd1) begin errors++; $display("FAIL t3_first got irq=%b id=%0d want 1/1", Interrupt, ActiveId); end
    IntReset = 1; tick();
    checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL t3_ack got %b want 0", Interrupt); end
    IntReset = 0; tick();
    checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL t3_gap got %b want 0", Interrupt); end
    tick();
    checks++; if (Interrupt !== 1'b1 || ActiveId !== 2'd3) begin errors++; $display("FAIL t3_second got irq=%b id=%0d want 1/3", Interrupt, ActiveId); end
    IntReset = 1; tick();
    IntReset = 0; tick(); tick();
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h0 || Interrupt !== 1'b0) begin errors++; $display("FAIL t3_drain got pend=%h irq=%b want 0/0", ReadData, Interrupt); end
  endtask

  task automatic test_enable_w1c();
    quiesce();
    irq_src = 4'b0001;
    repeat (4) tick();
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h1 || Interrupt !== 1'b0) begin errors++; $display("FAIL t4_masked got pend=%h irq=%b want 1/0", ReadData, Interrupt); end
    bus_write(BASE + 4, 32'h1);
    checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL t4_en_early got %b want 0", Interrupt); end
    tick();
    checks++; if (Interrupt !== 1'b1 || ActiveId !== 2'd0) begin errors++; $display("FAIL t4_en got irq=%b id=%0d want 1/0", Interrupt, ActiveId); end
    IntReset = 1; tick(); IntReset = 0; tick(); tick();
    bus_write(BASE + 4, 32'h0);
    irq_src = 0; repeat (3) tick();
    irq_src = 4'b0001; repeat (4) tick();
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL t4_repend got %h want 1", ReadData); end
    bus_write(BASE, 32'hF);
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h0 || Interrupt !== 1'b0) begin errors++; $display("FAIL t4_w1c got pend=%h irq=%b want 0/0", ReadData, Interrupt); end
  endtask

  task automatic test_set_wins();
    quiesce();
    irq_src = 4'b0010; repeat (4) tick();
    irq_src = 0; repeat (3) tick();
    irq_src = 4'b0010;
    tick(); tick();                 // edges k, k+1
    bus_write(BASE, 32'h2);         // edge k+2 carries both set and clear
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL t5_set_wins got %h want 2", ReadData); end
    bus_write(BASE, 32'h2);
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL t5_plain_w1c got %h want 0", ReadData); end
  endtask

  task automatic test_async_reset();
    quiesce();
    bus_write(BASE + 4, 32'hF);
    irq_src = 4'b1010;
    repeat (4) tick();
    Addr = BASE; #1;
    checks++; if (ReadData !== 32'hA || Interrupt !== 1'b1) begin errors++; $display("FAIL t6_pre got pend=%h irq=%b want a/1", ReadData, Interrupt); end
    #1 reset = 0; #1;
    checks++; if (ReadData !== 32'h0 || Interrupt !== 1'b0) begin errors++; $display("FAIL t6_async got pend=%h irq=%b want 0/0", ReadData, Interrupt); end
    irq_src = 0;
    tick();
    reset = 1;
    repeat (6) tick();
    checks++; if (Interrupt !== 1'b0 || ReadData !== 32'h0) begin errors++; $display("FAIL t6_post got irq=%b pend=%h want 0/0", Interrupt, ReadData); end
  endtask

  task automatic test_random();
    logic [31:0] er;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (Interrupt !== m_irq || ActiveId !== m_id) begin
        errors++; $display("FAIL rnd_out cyc%0d got irq=%b id=%0d want %b/%0d", c, Interrupt, ActiveId, m_irq, m_id);
      end
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
      if ($urandom_range(0, 3) == 0) IntReset = ~IntReset;
      MemWrite = ($urandom_range(0, 6) == 0);
      Addr = ($urandom_range(0, 7) == 0) ? BASE + 32'($urandom_range(4, 40) * 4)
                                          : BASE + 32'($urandom_range(0, 3) * 4);
      WriteData = $urandom;
      #1;
      er = exp_rd(Addr);
      checks++;
      if (ReadData !== er || Sel !== (Addr[31:4] == BASE[31:4])) begin
        errors++; $display("FAIL rnd_rd cyc%0d addr=%h got %h/%b want %h", c, Addr, ReadData, Sel, er);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 0; #1;
        checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL rnd_rst got %b want 0", Interrupt); end
        reset = 1;
      end
      tick();
    end
    MemWrite = 0; IntReset = 0; irq_src = 0;
  endtask

  initial begin
    test_reset();
    test_single_and_read();
    test_priority();
    test_enable_w1c();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
